// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: requester-side and register-bus-side signals of the arbiter
interface reg_bus_arbiter_if #(
   parameter int NumReq    = 2,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic [NumReq-1:0]             req_valid_i;
   logic [NumReq-1:0]             req_write_i;
   logic [NumReq*AddrWidth-1:0]   req_addr_i;
   logic [NumReq*DataWidth-1:0]   req_wdata_i;
   logic [NumReq*DataWidth/8-1:0] req_wstrb_i;
   logic [NumReq-1:0]             rsp_ready_o;
   logic [DataWidth-1:0]          rsp_rdata_o;
   logic                          rsp_error_o;
   logic                          reg_valid_o;
   logic                          reg_write_o;
   logic [AddrWidth-1:0]          reg_addr_o;
   logic [DataWidth-1:0]          reg_wdata_o;
   logic [DataWidth/8-1:0]        reg_wstrb_o;
   logic                          reg_ready_i;
   logic [DataWidth-1:0]          reg_rdata_i;
   logic                          reg_error_i;
   logic [NumReq-1:0]             grant_o;
   logic                          timeout_o;
   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
      input  reg_ready_i, reg_rdata_i, reg_error_i,
      output rsp_ready_o, rsp_rdata_o, rsp_error_o,
      output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
      output grant_o, timeout_o
   );
   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
      output reg_ready_i, reg_rdata_i, reg_error_i,
      input  rsp_ready_o, rsp_rdata_o, rsp_error_o,
      input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
      input  grant_o, timeout_o
   );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin owner of the register bus with one outstanding transaction and a wait timeout
module reg_bus_arbiter #(
   parameter int                   NumReq        = 2,
   parameter int                   AddrWidth     = 32,
   parameter int                   DataWidth     = 32,
   parameter int                   TimeoutCycles = 1024,
   parameter logic [DataWidth-1:0] ErrData       = 32'hBADCAB1E
) (
   input logic              clk_i,
   input logic              rst_i,
   reg_bus_arbiter_if.slave bus
);
   localparam int PW = NumReq > 1 ? $clog2(NumReq) : 1;
   localparam int CW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
   localparam int SW = DataWidth / 8;
   localparam logic [CW-1:0] LAST = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] sel;
   logic [CW-1:0] cnt;
   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] ptr, input int k);
      return PW'((int'(ptr) + k) % NumReq);
   endfunction
   // scanning downward lets the requester closest to rr_ptr overwrite the others
   always_comb begin
      sel = '0;
      for (int k = NumReq - 1; k >= 0; k--)
         if (bus.req_valid_i[wrap(rr_ptr, k)]) sel = wrap(rr_ptr, k);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         cnt             <= '0;
         bus.reg_valid_o <= 1'b0;
         bus.reg_write_o <= 1'b0;
         bus.reg_addr_o  <= '0;
         bus.reg_wdata_o <= '0;
         bus.reg_wstrb_o <= '0;
         bus.rsp_ready_o <= '0;
         bus.rsp_rdata_o <= '0;
         bus.rsp_error_o <= 1'b0;
         bus.grant_o     <= '0;
         bus.timeout_o   <= 1'b0;
      end else begin
         bus.rsp_ready_o <= '0;
         bus.timeout_o   <= 1'b0;
         case (state)
            IDLE: if (|bus.req_valid_i) begin
               bus.reg_write_o <= bus.req_write_i[sel];
               bus.reg_addr_o  <= bus.req_addr_i[sel*AddrWidth +: AddrWidth];
               bus.reg_wdata_o <= bus.req_wdata_i[sel*DataWidth +: DataWidth];
               bus.reg_wstrb_o <= bus.req_wstrb_i[sel*SW +: SW];
               bus.reg_valid_o <= 1'b1;
               bus.grant_o     <= NumReq'(1) << sel;
               rr_ptr          <= int'(sel) == NumReq - 1 ? '0 : sel + 1'b1;
               cnt             <= '0;
               state           <= BUSY;
            end
            BUSY: if (bus.reg_ready_i) begin
               bus.rsp_rdata_o <= bus.reg_rdata_i;
               bus.rsp_error_o <= bus.reg_error_i;
               bus.rsp_ready_o <= bus.grant_o;
               bus.reg_valid_o <= 1'b0;
               state           <= RESP;
            end else if (TimeoutCycles != 0 && cnt == LAST) begin
               bus.rsp_rdata_o <= ErrData;
               bus.rsp_error_o <= 1'b1;
               bus.rsp_ready_o <= bus.grant_o;
               bus.timeout_o   <= 1'b1;
               bus.reg_valid_o <= 1'b0;
               state           <= RESP;
            end else if (cnt != '1) cnt <= cnt + 1'b1;
            RESP: begin
               bus.grant_o <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
